config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
Drives the configuration shift chain of a column/array of clb_tile instances from the near (input) end. Accepts a stream of configuration words over a valid/ready interface and serialises them LSB-first onto the chain data input with the chain enable asserted. After exactly CHAIN_LEN bits it pulses the chain set line so the tiles commit their shadow configuration, then reports done. Sits between the host/bitstream buffer and the first tile's shift_in_hard/set_in_hard/cen.

Parameters:
WORD_WIDTH, 32, bits per input configuration word (>=2)
CHAIN_LEN, 1024, total bits in the attached shift chain (>=1)
SET_CYCLES, 1, cycles the set line is held high after shifting (>=1)
CNT_W, $clog2(CHAIN_LEN+1), width of the remaining-bit counter (derived; do not override)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a load; honoured only in IDLE
abort  input  1  synchronous abort; returns to IDLE from any state
word_data  input  WORD_WIDTH  configuration word, bit 0 shifted first
word_valid  input  1  word_data valid
word_ready  output  1  loader accepts word_data this cycle (transfer = valid & ready)
cfg_shift_in  output  1  serial data to first tile shift_in_hard
cfg_cen  output  1  chain shift enable to tiles' cen; high only on cycles a real bit is presented
cfg_set_in  output  1  commit pulse to first tile set_in_hard
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the set phase completes

Behaviour:
- Reset (rst low, async): state IDLE; word_ready, cfg_shift_in, cfg_cen, cfg_set_in, busy, done all 0; counters 0.
- States: IDLE, FETCH, SHIFT, SET, DONE.
- IDLE: start -> FETCH, remaining <= CHAIN_LEN. start while busy ignored.
- FETCH: word_ready=1, cfg_cen=0. On transfer: load shift reg, bit_idx<=0 -> SHIFT. No transfer: stay, cfg_shift_in holds last value.
- SHIFT: each cycle cfg_cen=1, cfg_shift_in=shreg[0]; shreg shifts right, bit_idx++, remaining--.
  - Word ends when bit_idx==WORD_WIDTH-1 or remaining==1.
  - Prefetch: word_ready=1 on a word's final bit cycle when remaining>1; transfer then reloads shreg and next cycle shifts bit 0 of the new word (zero-bubble streaming).
  - Word ends, remaining>1, no transfer -> FETCH (cfg_cen low during stall).
  - remaining==1 (last chain bit) -> SET; unshifted high bits of the final word are discarded; word_ready=0 on this cycle.
- SET: cfg_cen=0, cfg_set_in=1 for exactly SET_CYCLES cycles, then DONE.
- DONE: done=1 one cycle, busy=1, -> IDLE.
- word_ready is 0 in IDLE, SET, DONE; words offered then are not consumed.
- abort (any non-IDLE state): next cycle IDLE, all outputs 0, partial load not committed (no set pulse). abort in IDLE no effect. abort has priority over start and transfers.
- Async reset mid-load: immediate return to reset values; no set pulse.
- Total cfg_cen-high cycles per load is exactly CHAIN_LEN; total words consumed = ceil(CHAIN_LEN/WORD_WIDTH).

Test Plan:
- WORD_WIDTH=4, CHAIN_LEN=8, words 0xA,0x5 always valid -> cfg_shift_in 0,1,0,1,1,0,1,0 on 8 consecutive cfg_cen cycles, then cfg_set_in 1 cycle, done 1 cycle, busy low after.
- WORD_WIDTH=4, CHAIN_LEN=6, words 0x3,0xF -> bits 1,1,0,0,1,1; second word's upper 2 bits dropped; exactly 2 transfers; set follows immediately.
- Backpressure: word_valid drops 3 cycles between words -> cfg_cen low for those cycles, cfg_shift_in stable, bit sequence unchanged, total 8 cen cycles.
- abort asserted after 5 shifted bits -> IDLE next cycle, cfg_set_in never asserted, done never pulses; new start afterwards performs full clean load.
- rst pulled low during SHIFT -> all outputs 0 asynchronously; start during busy ignored (no restart, count unaffected).
- SET_CYCLES=3 -> cfg_set_in high exactly 3 consecutive cycles, cfg_cen low throughout, then done.

Source files
------------

// File: rtl/config_chain_loader.sv
// Serialises configuration words LSB-first onto a tile shift chain,
// then pulses the chain set line to commit the shadow configuration.
module config_chain_loader #(
   parameter int WORD_WIDTH = 32,
   parameter int CHAIN_LEN  = 1024,
   parameter int SET_CYCLES = 1,
   parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  cfg_shift_in,
   output logic                  cfg_cen,
   output logic                  cfg_set_in,
   output logic                  busy,
   output logic                  done
);

   localparam int BW = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;
   localparam int SW = $clog2(SET_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SHIFT,
      S_SET,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]         bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]      rem_q, rem_d;
   logic [SW-1:0]         set_cnt_q, set_cnt_d;
   logic                  last_q, last_d;
   logic                  word_end;
   logic                  last_bit;

   assign last_bit = (rem_q == CNT_W'(1));
   assign word_end = (bit_idx_q == BW'(WORD_WIDTH - 1)) || last_bit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         bit_idx_q <= '0;
         rem_q     <= '0;
         set_cnt_q <= '0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_idx_q <= bit_idx_d;
         rem_q     <= rem_d;
         set_cnt_q <= set_cnt_d;
         last_q    <= last_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_idx_d    = bit_idx_q;
      rem_d        = rem_q;
      set_cnt_d    = set_cnt_q;
      last_d       = last_q;
      word_ready   = 1'b0;
      cfg_shift_in = 1'b0;
      cfg_cen      = 1'b0;
      cfg_set_in   = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d   = S_FETCH;
               rem_d     = CNT_W'(CHAIN_LEN);
               bit_idx_d = '0;
               last_d    = 1'b0;
            end
         end
         S_FETCH: begin
            word_ready   = !abort;
            cfg_shift_in = last_q;
            if (word_valid && word_ready) begin
               shreg_d   = word_data;
               bit_idx_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            cfg_cen      = 1'b1;
            cfg_shift_in = shreg_q[0];
            last_d       = shreg_q[0];
            rem_d        = rem_q - CNT_W'(1);
            shreg_d      = shreg_q >> 1;
            bit_idx_d    = bit_idx_q + BW'(1);
            if (last_bit) begin
               state_d   = S_SET;
               set_cnt_d = '0;
            end else if (word_end) begin
               // Prefetch on the final bit keeps the chain streaming
               word_ready = !abort;
               if (word_valid && word_ready) begin
                  shreg_d   = word_data;
                  bit_idx_d = '0;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_SET: begin
            cfg_set_in   = 1'b1;
            cfg_shift_in = last_q;
            if (set_cnt_q == SW'(SET_CYCLES - 1)) begin
               state_d = S_DONE;
            end else begin
               set_cnt_d = set_cnt_q + SW'(1);
            end
         end
         S_DONE: begin
            done         = 1'b1;
            cfg_shift_in = last_q;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         rem_d     = '0;
         bit_idx_d = '0;
         set_cnt_d = '0;
         last_d    = 1'b0;
      end
   end

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: two instances cover
// the 8-bit/1-set and 6-bit/3-set chain configurations.
module tb_config_chain_loader;

   logic       clk;
   logic       rst;
   logic       start_a;
   logic       start_b;
   logic       abort;
   logic [3:0] word_data;
   logic       word_valid;
   logic       rdy_a, sin_a, cen_a, set_a, busy_a, done_a;
   logic       rdy_b, sin_b, cen_b, set_b, busy_b, done_b;

   int         total = 0;
   int         fails = 0;

   logic [31:0] seq;
   int ncen, nset, ndone, nxfer, nstall, bad, overlap;
   int first_set, last_set, last_cen, done_cyc;

   config_chain_loader #(
      .WORD_WIDTH(4),
      .CHAIN_LEN (8),
      .SET_CYCLES(1)
   ) u_a (
      .clk         (clk),
      .rst         (rst),
      .start       (start_a),
      .abort       (abort),
      .word_data   (word_data),
      .word_valid  (word_valid),
      .word_ready  (rdy_a),
      .cfg_shift_in(sin_a),
      .cfg_cen     (cen_a),
      .cfg_set_in  (set_a),
      .busy        (busy_a),
      .done        (done_a)
   );

   config_chain_loader #(
      .WORD_WIDTH(4),
      .CHAIN_LEN (6),
      .SET_CYCLES(3)
   ) u_b (
      .clk         (clk),
      .rst         (rst),
      .start       (start_b),
      .abort       (abort),
      .word_data   (word_data),
      .word_valid  (word_valid),
      .word_ready  (rdy_b),
      .cfg_shift_in(sin_b),
      .cfg_cen     (cen_b),
      .cfg_set_in  (set_b),
      .busy        (busy_b),
      .done        (done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int outs(input bit sel);
      if (sel) return int'({rdy_b, sin_b, cen_b, set_b, busy_b, done_b});
      return int'({rdy_a, sin_a, cen_a, set_a, busy_a, done_a});
   endfunction

   // Runs one load; called just after a rising edge.
   task automatic run(input bit sel, input logic [3:0] w0,
                      input logic [3:0] w1, input int gap,
                      input int abort_at, input int start_at,
                      input int rst_at);
      logic [3:0] words [2];
      bit xf, fin, seen_busy, afired, sfired;
      bit rdy, sin, cen, set, bsy, dn;
      int wi, gseen;
      words[0] = w0;
      words[1] = w1;
      seq = '0;
      ncen = 0; nset = 0; ndone = 0; nxfer = 0;
      nstall = 0; bad = 0; overlap = 0;
      first_set = -1; last_set = -1; last_cen = -1; done_cyc = -1;
      wi = 0; gseen = 0;
      fin = 0; seen_busy = 0; afired = 0; sfired = 0;
      word_data = w0;
      word_valid = 1'b1;
      if (sel) start_b = 1'b1;
      else start_a = 1'b1;
      for (int c = 0; c < 100 && !fin; c++) begin
         @(negedge clk);
         rdy = sel ? rdy_b : rdy_a;
         sin = sel ? sin_b : sin_a;
         cen = sel ? cen_b : cen_a;
         set = sel ? set_b : set_a;
         bsy = sel ? busy_b : busy_a;
         dn  = sel ? done_b : done_a;
         xf = word_valid && rdy;
         if (xf) nxfer++;
         if (!word_valid && rdy) gseen++;
         if (cen) begin
            seq[ncen] = sin;
            ncen++;
            last_cen = c;
         end
         if (set) begin
            nset++;
            if (first_set < 0) first_set = c;
            last_set = c;
            if (cen) overlap++;
         end
         if (dn) begin
            ndone++;
            done_cyc = c;
         end
         if (bsy && !cen && !set && !dn && ncen > 0) begin
            nstall++;
            if (sin != seq[ncen-1]) bad++;
         end
         if (bsy) seen_busy = 1;
         else if (seen_busy) fin = 1;
         if (ncen == rst_at) begin
            #2 rst = 1'b0;
            #1 chk("rst_async_outputs", outs(sel), 0);
            fin = 1;
         end
         if (!fin) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            start_b = 1'b0;
            abort = 1'b0;
            if (ncen == abort_at && !afired) begin
               abort = 1'b1;
               afired = 1;
            end
            if (ncen == start_at && !sfired) begin
               if (sel) start_b = 1'b1;
               else start_a = 1'b1;
               sfired = 1;
            end
            if (xf) begin
               wi++;
               gseen = 0;
            end
            word_valid = (wi < 2) && (wi == 0 || gseen >= gap);
            word_data = words[(wi < 2) ? wi : 1];
         end
      end
      chk("load_terminates", int'(fin), 1);
      word_valid = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      abort = 1'b0;
      word_data = '0;
      word_valid = 1'b0;

      #3;
      chk("reset_outs_a", outs(0), 0);
      chk("reset_outs_b", outs(1), 0);
      @(negedge clk);
      rst = 1'b1;

      // Words offered while idle must not be accepted
      @(posedge clk);
      #1;
      word_valid = 1'b1;
      word_data = 4'hA;
      repeat (2) @(negedge clk);
      chk("idle_ready_a", int'(rdy_a), 0);
      chk("idle_ready_b", int'(rdy_b), 0);
      chk("idle_busy_a", int'(busy_a), 0);
      word_valid = 1'b0;

      // 8-bit chain, streaming, start re-pulsed mid-load
      @(posedge clk);
      #1;
      run(0, 4'hA, 4'h5, 0, -1, 3, -1);
      chk("t1_bits", int'(seq[7:0]), 'h5A);
      chk("t1_cen_cycles", ncen, 8);
      chk("t1_xfers", nxfer, 2);
      chk("t1_set_cycles", nset, 1);
      chk("t1_done", ndone, 1);
      chk("t1_set_after_shift", first_set, last_cen + 1);
      chk("t1_done_after_set", done_cyc, last_set + 1);
      chk("t1_stalls", nstall, 0);
      chk("t1_set_cen_overlap", overlap, 0);

      // 6-bit chain, top bits of last word dropped, 3 set cycles
      @(posedge clk);
      #1;
      run(1, 4'h3, 4'hF, 0, -1, -1, -1);
      chk("t2_bits", int'(seq[5:0]), 'h33);
      chk("t2_cen_cycles", ncen, 6);
      chk("t2_xfers", nxfer, 2);
      chk("t2_set_cycles", nset, 3);
      chk("t2_set_contiguous", last_set - first_set, 2);
      chk("t2_set_after_shift", first_set, last_cen + 1);
      chk("t2_done_after_set", done_cyc, last_set + 1);
      chk("t2_done", ndone, 1);
      chk("t2_set_cen_overlap", overlap, 0);

      // Backpressure: three stall cycles between words
      @(posedge clk);
      #1;
      run(0, 4'hA, 4'h5, 3, -1, -1, -1);
      chk("t3_bits", int'(seq[7:0]), 'h5A);
      chk("t3_cen_cycles", ncen, 8);
      chk("t3_stalls", nstall, 3);
      chk("t3_stall_data_stable", bad, 0);
      chk("t3_set_cycles", nset, 1);
      chk("t3_done", ndone, 1);

      // Abort after five bits: no commit
      @(posedge clk);
      #1;
      run(0, 4'hA, 4'h5, 0, 5, -1, -1);
      chk("t4_cen_cycles", ncen, 6);
      chk("t4_no_set", nset, 0);
      chk("t4_no_done", ndone, 0);
      chk("t4_idle_outs", outs(0), 0);

      @(posedge clk);
      #1;
      run(0, 4'h5, 4'hA, 0, -1, -1, -1);
      chk("t4b_bits", int'(seq[7:0]), 'hA5);
      chk("t4b_cen_cycles", ncen, 8);
      chk("t4b_set_cycles", nset, 1);
      chk("t4b_done", ndone, 1);

      // Asynchronous reset mid-shift
      @(posedge clk);
      #1;
      run(0, 4'hA, 4'h5, 0, -1, -1, 4);
      chk("t5_no_set", nset, 0);
      @(negedge clk);
      chk("t5_held_outs", outs(0), 0);
      rst = 1'b1;

      @(posedge clk);
      #1;
      run(0, 4'hC, 4'h3, 0, -1, -1, -1);
      chk("t5b_bits", int'(seq[7:0]), 'h3C);
      chk("t5b_cen_cycles", ncen, 8);
      chk("t5b_done", ndone, 1);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
